ex_mem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It sits between the execute stage (producer) and the memory stage (consumer). The register holds the ALU result, store data, destination register and the MEM/WB control bits. Beyond a plain clocked latch it adds backpressure (stall without losing data), a synchronous flush for branch mispredict, and bubble insertion: control bits read as zero whenever no valid instruction is presented.

---
 rtl/ex_mem_pipe_reg.sv | 112 +++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The head entry drives the outputs. Control bits are forced to zero whenever no valid instruction is held.
module ex_mem_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result_in,
  input  logic [DATA_W-1:0]     write_data_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     write_data_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic                  branch_out,
  output logic                  mem_read_out,
  output logic                  mem_write_out,
  output logic                  mem_to_reg_out,
  output logic                  reg_write_out,
  output logic [1:0]            occupancy
);

  localparam int CTRL_W = 5;
  localparam int ENT_W  = 2 * DATA_W + REG_ADDR_W + CTRL_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [ENT_W-1:0]   head_reg;
  logic [ENT_W-1:0]   skid_reg;
  logic [ENT_W-1:0]   in_entry;
  logic               accept;
  logic               release_evt;
  logic [CTRL_W-1:0]  head_ctrl;
  logic [CTRL_W-1:0]  ctrl_gated;

  // Entry layout: {alu_result, write_data, write_reg, branch, mem_read, mem_write, mem_to_reg, reg_write}
  assign in_entry = {alu_result_in, write_data_in, write_reg_in,
                     branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in};

  // Handshake flags depend only on registered state.
  assign in_ready    = (state_reg != FULL);
  assign out_valid   = (state_reg != EMPTY);
  assign occupancy   = 2'(state_reg);
  assign accept      = in_valid && in_ready;
  assign release_evt = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else if (flush) begin
      state_reg <= EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            head_reg  <= in_entry;
            state_reg <= ONE;
          end
        end
        ONE: begin
          if (accept && release_evt) begin
            head_reg <= in_entry;
          end else if (accept) begin
            skid_reg  <= in_entry;
            state_reg <= FULL;
          end else if (release_evt) begin
            state_reg <= EMPTY;
          end
        end
        FULL: begin
          if (release_evt) begin
            head_reg  <= skid_reg;
            state_reg <= ONE;
          end
        end
        default: state_reg <= EMPTY;
      endcase
    end
  end

  assign alu_result_out = head_reg[ENT_W-1 -: DATA_W];
  assign write_data_out = head_reg[ENT_W-DATA_W-1 -: DATA_W];
  assign write_reg_out  = head_reg[CTRL_W +: REG_ADDR_W];
  assign head_ctrl      = head_reg[CTRL_W-1:0];

  // A bubble must never carry live control into the memory stage.
  generate
    for (genvar gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
      assign ctrl_gated[gi] = head_ctrl[gi] & out_valid;
    end
  endgenerate

  assign {branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out} = ctrl_gated;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: directed scenarios followed by random valid/ready/flush traffic.
// Expected entries are held in a FIFO of at most two items.
module tb_ex_mem_pipe_reg;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        br;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rw;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_result_in, write_data_in, alu_result_out, write_data_out;
  logic [4:0]  write_reg_in, write_reg_out;
  logic        branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
  logic        branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out;
  logic [1:0]  occupancy;

  ent_t exp_q[$];
  logic rel_pend  = 1'b0;
  logic zero_data = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in), .write_reg_in(write_reg_in),
    .branch_in(branch_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .write_data_out(write_data_out), .write_reg_out(write_reg_out),
    .branch_out(branch_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
    .occupancy(occupancy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record its effect on the expected FIFO.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic rst, input ent_t e);
    int pre;
    @(negedge clk);
    #1;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    alu_result_in = e.alu; write_data_in = e.wd; write_reg_in = e.wr;
    {branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in} = {e.br, e.mr, e.mw, e.m2r, e.rw};
    pre = exp_q.size();
    rel_pend = (pre > 0) && ordy && !rst && !fl;
    if (rst || fl) begin
      exp_q.delete();
      if (rst) zero_data = 1'b1;
    end else if (iv && pre < 2) begin
      exp_q.push_back(e);
    end
    $display("cyc t=%0t rst=%0b fl=%0b iv=%0b ordy=%0b alu=%0h held=%0d", $time, rst, fl, iv, ordy, e.alu, exp_q.size());
  endtask

  function automatic ent_t mk(input logic [31:0] alu, input logic [4:0] wr, input logic mw, input logic rw);
    ent_t e;
    e = '0;
    e.alu = alu; e.wd = alu ^ 32'h5A5A_0000; e.wr = wr; e.mw = mw; e.rw = rw;
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.alu = $urandom; e.wd = $urandom; e.wr = 5'($urandom);
    {e.br, e.mr, e.mw, e.m2r, e.rw} = 5'($urandom);
    return e;
  endfunction

  // Monitor: retire the entry released at the last edge, then compare the DUT against the FIFO.
  initial begin
    ent_t h;
    forever begin
      @(negedge clk);
      if (rel_pend && exp_q.size() > 0) void'(exp_q.pop_front());
      rel_pend = 1'b0;
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        zero_data = 1'b0;
        chk("alu_result_out", 64'(alu_result_out), 64'(h.alu));
        chk("write_data_out", 64'(write_data_out), 64'(h.wd));
        chk("write_reg_out", 64'(write_reg_out), 64'(h.wr));
        chk("ctrl_out", 64'({branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out}),
            64'({h.br, h.mr, h.mw, h.m2r, h.rw}));
      end else begin
        chk("ctrl_bubble", 64'({branch_out, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out}), 64'(0));
        if (zero_data) begin
          chk("data_after_reset", 64'({alu_result_out, write_reg_out}), 64'(0));
          chk("wdata_after_reset", 64'(write_data_out), 64'(0));
        end
      end
    end
  end

  initial begin
    ent_t z;
    z = '0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    alu_result_in = 32'h1234; write_data_in = 32'h5678; write_reg_in = 5'd7;
    {branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in} = 5'b11111;

    // Reset held two cycles while EX claims a valid instruction.
    step(1'b1, 1'b0, 1'b0, 1'b1, mk(32'h1234, 5'd7, 1'b1, 1'b1));
    step(1'b1, 1'b1, 1'b0, 1'b1, mk(32'h1234, 5'd7, 1'b1, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0, z);

    // Streaming at full throughput.
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h10, 5'd1, 1'b0, 1'b1));
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h20, 5'd2, 1'b0, 1'b1));
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h30, 5'd3, 1'b0, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b1, 1'b0, 1'b0, z);

    // Backpressure: fill both slots, offer a third, then drain.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'hA, 5'd3, 1'b0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'hB, 5'd4, 1'b0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'hC, 5'd5, 1'b0, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b1, 1'b0, 1'b0, z);

    // Flush while full with a simultaneous offer that must be discarded.
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1A, 5'd6, 1'b1, 1'b1));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1B, 5'd7, 1'b1, 1'b1));
    step(1'b1, 1'b0, 1'b1, 1'b0, mk(32'hD, 5'd8, 1'b1, 1'b1));
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b1, 1'b0, 1'b0, z);

    // Bubble: a store is consumed and the stage goes idle.
    step(1'b1, 1'b1, 1'b0, 1'b0, mk(32'hE0, 5'd9, 1'b1, 1'b0));
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b0, 1'b0, 1'b0, z);
    step(1'b0, 1'b0, 1'b0, 1'b0, z);

    // Random traffic with occasional flush and rarer reset.
    for (int i = 0; i < 10000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 499) == 0), rnd_ent());
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    step(1'b0, 1'b1, 1'b0, 1'b0, z);
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
